// File: rtl/morse_decoder.sv
// Morse key decoder: synchronise and debounce the key, time marks and gaps with
// one duration counter, and decode each symbol into an ASCII character code.
module morse_decoder #(
  parameter  int UNIT_CYC = 5000000,
  parameter  int DEB_CYC  = 500000,
  localparam int CHAR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key,
  output logic [CHAR_W-1:0] char,
  output logic              char_valid,
  output logic              err,
  output logic              word_end,
  output logic              key_db
);

  localparam logic [CHAR_W-1:0] CHAR_CODE_0 = 8'h30;

  localparam int CNT_W   = $clog2(7 * UNIT_CYC + 1);
  localparam int DEB_W   = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(7 * UNIT_CYC);
  localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(2 * UNIT_CYC);
  localparam logic [CNT_W-1:0] WORD_LIM = CNT_W'(5 * UNIT_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MARK     = 2'd1,
    SPACE    = 2'd2,
    WORDWAIT = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_key_db;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        r_pat;
  logic [2:0]        r_len;
  logic              r_ovf;
  logic [CHAR_W-1:0] r_char;
  logic              r_char_valid;
  logic              r_err;
  logic              r_word_end;

  logic              w_db_flip;
  logic              w_rise;
  logic              w_fall;
  logic              w_elem;
  logic [CHAR_W:0]   w_dec;

  // Returns {hit, ascii}; unused upper pattern bits are always zero.
  function automatic logic [CHAR_W:0] decode(input logic [2:0] len, input logic [4:0] pat);
    logic [7:0] c;
    c = 8'h00;
    case ({len, pat})
      {3'd1, 5'b00000}: c = "E";
      {3'd1, 5'b00001}: c = "T";
      {3'd2, 5'b00000}: c = "I";
      {3'd2, 5'b00001}: c = "A";
      {3'd2, 5'b00010}: c = "N";
      {3'd2, 5'b00011}: c = "M";
      {3'd3, 5'b00000}: c = "S";
      {3'd3, 5'b00001}: c = "U";
      {3'd3, 5'b00010}: c = "R";
      {3'd3, 5'b00011}: c = "W";
      {3'd3, 5'b00100}: c = "D";
      {3'd3, 5'b00101}: c = "K";
      {3'd3, 5'b00110}: c = "G";
      {3'd3, 5'b00111}: c = "O";
      {3'd4, 5'b00000}: c = "H";
      {3'd4, 5'b00001}: c = "V";
      {3'd4, 5'b00010}: c = "F";
      {3'd4, 5'b00100}: c = "L";
      {3'd4, 5'b00110}: c = "P";
      {3'd4, 5'b00111}: c = "J";
      {3'd4, 5'b01000}: c = "B";
      {3'd4, 5'b01001}: c = "X";
      {3'd4, 5'b01010}: c = "C";
      {3'd4, 5'b01011}: c = "Y";
      {3'd4, 5'b01100}: c = "Z";
      {3'd4, 5'b01101}: c = "Q";
      {3'd5, 5'b00000}: c = "5";
      {3'd5, 5'b00001}: c = "4";
      {3'd5, 5'b00011}: c = "3";
      {3'd5, 5'b00111}: c = "2";
      {3'd5, 5'b01111}: c = "1";
      {3'd5, 5'b10000}: c = "6";
      {3'd5, 5'b11000}: c = "7";
      {3'd5, 5'b11100}: c = "8";
      {3'd5, 5'b11110}: c = "9";
      {3'd5, 5'b11111}: c = "0";
      default:          c = 8'h00;
    endcase
    return {(c != 8'h00), c};
  endfunction

  always_comb begin
    w_db_flip = (r_sync2 != r_key_db) && (r_deb_cnt == DEB_LAST);
    w_rise    = w_db_flip && r_sync2;
    w_fall    = w_db_flip && !r_sync2;
    w_elem    = (r_cnt >= DOT_LIM);
    w_dec     = decode(r_len, r_pat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_key_db     <= 1'b0;
      r_deb_cnt    <= '0;
      r_cnt        <= '0;
      r_pat        <= '0;
      r_len        <= '0;
      r_ovf        <= 1'b0;
      r_char       <= CHAR_CODE_0;
      r_char_valid <= 1'b0;
      r_err        <= 1'b0;
      r_word_end   <= 1'b0;
    end else begin
      r_sync1      <= key;
      r_sync2      <= r_sync1;
      r_char_valid <= 1'b0;
      r_err        <= 1'b0;
      r_word_end   <= 1'b0;

      // The debounce run restarts whenever the synchronised key agrees again.
      if (r_sync2 == r_key_db || w_db_flip) begin
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
      if (w_db_flip) begin
        r_key_db <= r_sync2;
      end

      if (w_db_flip) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_rise) r_state <= MARK;
        end
        MARK: begin
          if (w_fall) begin
            r_state <= SPACE;
            if (r_len == 3'd5) begin
              r_ovf <= 1'b1;
            end else begin
              r_pat <= {r_pat[3:0], w_elem};
              r_len <= r_len + 3'd1;
            end
          end
        end
        SPACE: begin
          if (w_rise) begin
            r_state <= MARK;
          end else if (r_cnt == DOT_LIM) begin
            if (r_ovf || !w_dec[CHAR_W]) begin
              r_err <= 1'b1;
            end else begin
              r_char       <= w_dec[CHAR_W-1:0];
              r_char_valid <= 1'b1;
            end
            r_pat   <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
            r_state <= WORDWAIT;
          end
        end
        WORDWAIT: begin
          if (w_rise) begin
            r_state <= MARK;
          end else if (r_cnt == WORD_LIM) begin
            r_word_end <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign char       = r_char;
  assign char_valid = r_char_valid;
  assign err        = r_err;
  assign word_end   = r_word_end;
  assign key_db     = r_key_db;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with UNIT_CYC=10, DEB_CYC=2: keys symbols,
// counts strobes in a monitor and compares against hand-worked expectations.
module tb_morse_decoder;

  localparam int UNIT = 10;
  localparam int DEB  = 2;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic [7:0] char;
  logic       char_valid;
  logic       err;
  logic       word_end;
  logic       key_db;

  int n_cmp;
  int n_bad;

  int n_cv;
  int n_err;
  int n_we;
  int n_db_rise;
  int n_overlap;
  int cyc;
  int cv_cyc;
  int we_cyc;
  logic prev_db;

  morse_decoder #(.UNIT_CYC(UNIT), .DEB_CYC(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .char       (char),
    .char_valid (char_valid),
    .err        (err),
    .word_end   (word_end),
    .key_db     (key_db)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: outputs sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (char_valid) begin
      n_cv   = n_cv + 1;
      cv_cyc = cyc;
    end
    if (err) n_err = n_err + 1;
    if (word_end) begin
      n_we   = n_we + 1;
      we_cyc = cyc;
    end
    if ((int'(char_valid) + int'(err) + int'(word_end)) > 1) n_overlap = n_overlap + 1;
    if (key_db && !prev_db) n_db_rise = n_db_rise + 1;
    prev_db = key_db;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // driver tasks
  task automatic hold(input logic lvl, input int n);
    key = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_cv      = 0;
    n_err     = 0;
    n_we      = 0;
    n_db_rise = 0;
    cv_cyc    = 0;
    we_cyc    = 0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; n_overlap = 0; prev_db = 1'b0;
    clear_counts();
    key   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_char",   int'(char), 8'h30);
    check("rst_cv",     int'(char_valid), 0);
    check("rst_err",    int'(err), 0);
    check("rst_we",     int'(word_end), 0);
    check("rst_key_db", int'(key_db), 0);
    rst_n = 1'b1;
    hold(1'b0, 20);
    check("idle_quiet", n_cv + n_err + n_we, 0);

    // ".-" = A
    clear_counts();
    hold(1'b1, 10);
    check("a_db_high", int'(key_db), 1);
    hold(1'b0, 10);
    check("a_db_low", int'(key_db), 0);
    hold(1'b1, 30);
    hold(1'b0, 30);
    check("a_cv",   n_cv, 1);
    check("a_char", int'(char), "A");
    check("a_err",  n_err, 0);
    check("a_we",   n_we, 0);
    hold(1'b0, 40);
    check("a_we_late", n_we, 1);

    // "-----" = 0, followed by a word gap
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 30);
      if (i < 4) hold(1'b0, 10);
    end
    hold(1'b0, 80);
    check("z_cv",    n_cv, 1);
    check("z_char",  int'(char), "0");
    check("z_err",   n_err, 0);
    check("z_we",    n_we, 1);
    check("z_we_dt", we_cyc - cv_cyc, 3 * UNIT);

    // six dots: overflow
    clear_counts();
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, 10);
      hold(1'b0, (i < 5) ? 10 : 30);
    end
    check("ovf_err",  n_err, 1);
    check("ovf_cv",   n_cv, 0);
    check("ovf_char", int'(char), "0");
    hold(1'b0, 40);

    // "----" is unassigned
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 30);
      hold(1'b0, (i < 3) ? 10 : 30);
    end
    check("unk_err", n_err, 1);
    check("unk_cv",  n_cv, 0);
    hold(1'b0, 40);

    // held press saturates, still a dash = T
    clear_counts();
    hold(1'b1, 90);
    check("hold_quiet", n_cv + n_err + n_we, 0);
    hold(1'b0, 30);
    check("hold_cv",   n_cv, 1);
    check("hold_char", int'(char), "T");
    hold(1'b0, 40);

    // 1-cycle glitch in IDLE
    clear_counts();
    hold(1'b1, 1);
    hold(1'b0, 30);
    check("glitch_db",  n_db_rise, 0);
    check("glitch_str", n_cv + n_err + n_we, 0);

    // press with a 1-cycle dropout is still one dot = E
    clear_counts();
    hold(1'b1, 5);
    hold(1'b0, 1);
    hold(1'b1, 5);
    hold(1'b0, 30);
    check("drop_db",   n_db_rise, 1);
    check("drop_cv",   n_cv, 1);
    check("drop_err",  n_err, 0);
    check("drop_char", int'(char), "E");
    hold(1'b0, 40);

    // reset mid-symbol after two dots
    clear_counts();
    hold(1'b1, 10);
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 5);
    rst_n = 1'b0;
    hold(1'b0, 3);
    rst_n = 1'b1;
    check("mrst_char", int'(char), 8'h30);
    hold(1'b0, 100);
    check("mrst_quiet", n_cv + n_err + n_we, 0);
    clear_counts();
    hold(1'b1, 10);
    hold(1'b0, 30);
    check("mrst_cv",   n_cv, 1);
    check("mrst_char2", int'(char), "E");
    check("mrst_err",  n_err, 0);

    check("excl", n_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
